bus_reg_slave: RTL and testbench
================================

// Module: bus_reg_slave
// PURPOSE
//   Registered bus target that sits directly downstream of the bus master stage.
//   Consumes valid/we/addr/wdata requests and returns rdata/ready/err after a
//   programmable number of wait states.
//   Backs a 2**ADDR_W-entry register file; entry 0 is a read-only ID register.
//   bus_out exports a status word (busy + completed-transaction count) to the parent.
// PARAMETERS
//   ADDR_W       4    address width; register file depth is 2**ADDR_W
//   DATA_W       4    data width of wdata/rdata and of each register
//   WAIT_CYCLES  2    wait states between accept and response; legal 0..15
//   ID_VAL       4'h5 value returned on reads of address 0
// PORTS
//   clock    in   1       single clock; all state updates on rising edge
//   reset    in   1       synchronous, active-high reset
//   valid    in   1       request valid from master
//   we       in   1       1 = write, 0 = read; sampled with valid
//   addr     in   ADDR_W  request address
//   wdata    in   DATA_W  write data
//   rdata    out  DATA_W  read data; valid while ready=1 for reads
//   ready    out  1       one-cycle response strobe; completes the transaction
//   err      out  1       qualifies ready: write to read-only address 0
//   bus_out  out  5       {busy, txn_count[3:0]}
// BEHAVIOUR
//   Reset (reset=1 at a clock edge):
//     - state <= IDLE; all registers 1..N-1 <= 0.
//     - rdata, ready, err, txn_count, busy <= 0.
//     - Reset mid-transaction aborts it: no write commit, no ready.
//   FSM: IDLE -> WAIT -> RESP -> IDLE.
//     - IDLE: ready=0, busy=0. On valid=1, capture we/addr/wdata, load cnt <= WAIT_CYCLES.
//       Go to WAIT if WAIT_CYCLES>0, else go to RESP.
//     - WAIT: busy=1. cnt decrements each cycle; go to RESP when cnt reaches 1.
//     - RESP: ready=1 for exactly one cycle, busy=1, then go to IDLE.
//   Latency: valid accepted in IDLE at cycle N -> ready=1 in cycle N+1+WAIT_CYCLES.
//   Throughput: at least one IDLE cycle between responses.
//     - A valid held high through RESP is treated as a new request in the following IDLE cycle.
//     - Back-to-back period is WAIT_CYCLES+2 cycles.
//   Handshake:
//     - Master holds request until ready.
//     - Input changes during WAIT/RESP are ignored; captured values are used.
//     - valid dropping before ready does not cancel the transaction.
//   Writes (captured we=1):
//     - Addr!=0: reg[addr] <= wdata at the RESP clock edge; err=0.
//     - Addr==0: no update; err=1 with ready.
//   Reads (captured we=0):
//     - rdata = ID_VAL for addr 0, else reg[addr]; registered and presented with ready.
//     - rdata holds its value until the next read response; writes leave rdata unchanged.
//   Ordering: a read immediately after a write to the same address returns the new data.
//   Reads of never-written entries return 0.
//   txn_count: +1 on every ready (incl. err), modulo 16; wraps 15 -> 0.
//   err is 0 whenever ready=0.
// TESTING
//   1. WAIT=2: write addr 3 = 4'hA at cycle 0 -> ready=1, err=0 at cycle 3.
//      Then read addr 3 -> rdata=4'hA with ready.
//   2. Read addr 0 -> rdata=4'h5.
//      Write addr 0 = 4'hF -> ready=1, err=1.
//      Re-read addr 0 -> still 4'h5.
//   3. valid held high over 3 reads -> ready pulses every 4 cycles; bus_out[4] low only in IDLE cycles.
//   4. Assert reset during WAIT of a write to addr 7 -> no ready.
//      Later read of addr 7 returns 0; bus_out=0.
//   5. 17 transactions -> bus_out[3:0] reads 0 after the 16th response, then 1 after the 17th.
//   6. WAIT_CYCLES=0: valid at cycle N -> ready at N+1.
//      Read of unwritten addr 9 -> rdata=0.

Source files
------------

// File: rtl/bus_reg_slave.sv
// bus_reg_slave: registered bus target with programmable wait states.
// Backs a 2**ADDR_W register file (entry 0 is a read-only ID register) and
// exports {busy, txn_count} to the parent on bus_out.
module bus_reg_slave #(
  parameter int unsigned         ADDR_W      = 4,
  parameter int unsigned         DATA_W      = 4,
  parameter int unsigned         WAIT_CYCLES = 2,
  parameter logic [DATA_W-1:0]   ID_VAL      = 'h5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic [4:0]        bus_out
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned TXN_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cap_we_q, cap_we_d;
  logic [ADDR_W-1:0]   cap_addr_q, cap_addr_d;
  logic [DATA_W-1:0]   cap_wdata_q, cap_wdata_d;

  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic [TXN_W-1:0]    txn_q, txn_d;
  logic                commit_c;

  logic [DATA_W-1:0]   regs_q [DEPTH];

  // State register: FSM state, wait counter and captured request
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cap_we_q    <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_we_q    <= cap_we_d;
      cap_addr_q  <= cap_addr_d;
      cap_wdata_q <= cap_wdata_d;
    end
  end

  // Next-state logic: accept in IDLE, count down wait states, single RESP cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_we_d    = cap_we_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (valid) begin
          cap_we_d    = we;
          cap_addr_d  = addr;
          cap_wdata_d = wdata;
          cnt_d       = CNT_W'(WAIT_CYCLES);
          if (WAIT_CYCLES != 0) state_d = S_WAIT;
          else                  state_d = S_RESP;
        end
      end
      S_WAIT: begin
        if (cnt_q <= CNT_W'(1)) state_d = S_RESP;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: registered response values derived from the upcoming state
  always_comb begin
    ready_d  = 1'b0;
    err_d    = 1'b0;
    busy_d   = (state_d != S_IDLE);
    rdata_d  = rdata_q;
    txn_d    = txn_q;
    commit_c = 1'b0;
    if (state_d == S_RESP) begin
      ready_d = 1'b1;
      err_d   = cap_we_d && (cap_addr_d == '0);
      if (!cap_we_d) begin
        rdata_d = (cap_addr_d == '0) ? ID_VAL : regs_q[cap_addr_d];
      end
    end
    if (state_q == S_RESP) begin
      txn_d    = txn_q + TXN_W'(1);
      commit_c = cap_we_q && (cap_addr_q != '0);
    end
  end

  // Response registers and completed-transaction counter
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      txn_q   <= '0;
    end else begin
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      txn_q   <= txn_d;
    end
  end

  // Register file: write commits on the edge that closes the RESP cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
    end else if (commit_c) begin
      regs_q[cap_addr_q] <= cap_wdata_q;
    end
  end

  assign rdata   = rdata_q;
  assign ready   = ready_q;
  assign err     = err_q;
  assign bus_out = {busy_q, txn_q};

endmodule

// File: tb/tb_bus_reg_slave.sv
// Directed bench for bus_reg_slave: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances
// with a response scoreboard.
module tb_bus_reg_slave;

  logic       clock = 1'b0;
  logic       reset;
  logic       sel;
  logic       in_valid, in_we;
  logic [3:0] in_addr, in_wdata;

  logic       valid2, valid0;
  logic [3:0] rdata2, rdata0;
  logic       ready2, ready0, err2, err0;
  logic [4:0] bo2, bo0;

  logic [3:0] obs_rdata;
  logic       obs_ready, obs_err;
  logic [4:0] obs_bo;

  typedef struct {
    logic [3:0] rd;
    logic       err;
    bit         chk_rd;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_cnt [2];
  int   cyc = 0;
  int   c1, c2, c3;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign valid2    = in_valid & ~sel;
  assign valid0    = in_valid & sel;
  assign obs_rdata = sel ? rdata0 : rdata2;
  assign obs_ready = sel ? ready0 : ready2;
  assign obs_err   = sel ? err0   : err2;
  assign obs_bo    = sel ? bo0    : bo2;

  bus_reg_slave #(.ADDR_W(4), .DATA_W(4), .WAIT_CYCLES(2), .ID_VAL(4'h5)) dut2 (
    .clock(clock), .reset(reset), .valid(valid2), .we(in_we), .addr(in_addr),
    .wdata(in_wdata), .rdata(rdata2), .ready(ready2), .err(err2), .bus_out(bo2)
  );

  bus_reg_slave #(.ADDR_W(4), .DATA_W(4), .WAIT_CYCLES(0), .ID_VAL(4'h5)) dut0 (
    .clock(clock), .reset(reset), .valid(valid0), .we(in_we), .addr(in_addr),
    .wdata(in_wdata), .rdata(rdata0), .ready(ready0), .err(err0), .bus_out(bo0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction on the selected instance; hold keeps valid high past ready.
  task automatic txn(input bit w, input logic [3:0] a, input logic [3:0] d,
                     input logic [3:0] exp_rd, input bit exp_err, input bit hold);
    exp_t e;
    bit   got;
    int   lat;
    int   exp_wait;
    exp_wait = sel ? 0 : 2;
    @(posedge clock); #1;
    chk("idle_busout", 32'(obs_bo), 32'({1'b0, 4'(exp_cnt[sel])}));
    in_valid = 1'b1; in_we = w; in_addr = a; in_wdata = d;
    sb.push_back('{rd: exp_rd, err: exp_err, chk_rd: !w});
    got = 1'b0;
    lat = 0;
    for (int k = 0; k < 24 && !got; k++) begin
      @(negedge clock);
      if (obs_ready === 1'b1) begin
        got = 1'b1;
        lat = k;
      end else begin
        chk("err_without_ready", 32'(obs_err), 32'(0));
        chk("busy", 32'(obs_bo[4]), 32'(k != 0));
        if (k == 1) begin
          // Scramble inputs during WAIT: captured values must be used.
          in_we = ~w; in_addr = ~a; in_wdata = ~d;
          if (!hold) in_valid = 1'b0;
        end
      end
    end
    chk("ready_seen", 32'(got), 32'(1));
    if (got) begin
      chk("latency", 32'(lat), 32'(exp_wait + 1));
      chk("busy_resp", 32'(obs_bo[4]), 32'(1));
      e = sb.pop_front();
      chk("err", 32'(obs_err), 32'(e.err));
      if (e.chk_rd) chk("rdata", 32'(obs_rdata), 32'(e.rd));
      exp_cnt[sel] = (exp_cnt[sel] + 1) % 16;
    end else begin
      void'(sb.pop_front());
    end
    if (!hold) in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0;
    in_valid = 1'b0; in_we = 1'b0; in_addr = '0; in_wdata = '0;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_rdata",   32'(rdata2), 32'(0));
    chk("rst_ready",   32'(ready2), 32'(0));
    chk("rst_err",     32'(err2),   32'(0));
    chk("rst_busout",  32'(bo2),    32'(0));
    chk("rst_busout0", 32'(bo0),    32'(0));

    // Write then read back; ID register reads and read-only write error
    txn(1'b1, 4'd3, 4'hA, 4'h0, 1'b0, 1'b0);
    txn(1'b0, 4'd3, 4'h0, 4'hA, 1'b0, 1'b0);
    txn(1'b0, 4'd0, 4'h0, 4'h5, 1'b0, 1'b0);
    txn(1'b1, 4'd0, 4'hF, 4'h0, 1'b1, 1'b0);
    chk("rdata_hold_err_write", 32'(rdata2), 32'(5));
    txn(1'b0, 4'd0, 4'h0, 4'h5, 1'b0, 1'b0);
    txn(1'b1, 4'd4, 4'hC, 4'h0, 1'b0, 1'b0);
    chk("rdata_hold_write", 32'(rdata2), 32'(5));

    // Valid held high across three reads: back-to-back period is 4 cycles
    txn(1'b0, 4'd3, 4'h0, 4'hA, 1'b0, 1'b1); c1 = cyc;
    txn(1'b0, 4'd0, 4'h0, 4'h5, 1'b0, 1'b1); c2 = cyc;
    txn(1'b0, 4'd4, 4'h0, 4'hC, 1'b0, 1'b0); c3 = cyc;
    chk("period_1", 32'(c2 - c1), 32'(4));
    chk("period_2", 32'(c3 - c2), 32'(4));

    // Reset during WAIT of a write to addr 7 aborts it
    @(posedge clock); #1;
    in_valid = 1'b1; in_we = 1'b1; in_addr = 4'd7; in_wdata = 4'h9;
    @(negedge clock);
    @(negedge clock);
    chk("busy_before_abort", 32'(bo2[4]), 32'(1));
    in_valid = 1'b0; reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("no_ready_after_abort", 32'(ready2), 32'(0));
    end
    chk("abort_busout", 32'(bo2), 32'(0));
    chk("abort_rdata", 32'(rdata2), 32'(0));
    txn(1'b0, 4'd7, 4'h0, 4'h0, 1'b0, 1'b0);

    // 17 transactions from reset: count wraps to 0 after the 16th
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    for (int i = 0; i < 16; i++) begin
      txn(1'b1, 4'(i), 4'(i), 4'h0, (i == 0), 1'b0);
    end
    @(posedge clock); #1;
    chk("count_after_16", 32'(bo2[3:0]), 32'(0));
    txn(1'b0, 4'd5, 4'h0, 4'h5, 1'b0, 1'b0);
    @(posedge clock); #1;
    chk("count_after_17", 32'(bo2[3:0]), 32'(1));

    // Zero wait states: response one cycle after accept
    sel = 1'b1;
    txn(1'b1, 4'd2, 4'h3, 4'h0, 1'b0, 1'b0);
    txn(1'b0, 4'd9, 4'h0, 4'h0, 1'b0, 1'b0);
    txn(1'b0, 4'd2, 4'h0, 4'h3, 1'b0, 1'b0);
    txn(1'b1, 4'd0, 4'h1, 4'h0, 1'b1, 1'b0);
    txn(1'b0, 4'd0, 4'h0, 4'h5, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
